inference_scheduler: RTL

Per-frame sequencer for the camera-to-LeNet datapath, clocked on clk24. It arms capture for one frame and starts the core downscale pass when capture ends. When the core finishes it launches LeNet inference and latches the digit on completion. It also counts processed frames and flags a stalled stage with a watchdog. Control inputs come from the run switch (enable) and the pause switch (pause).

---
 rtl/inference_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/inference_scheduler.sv
// Per-frame sequencer: capture -> core downscale -> LeNet -> digit latch.
// Ports: clk24/rst, enable/pause levels, capture_end/core_end pulses,
//   lenet_ready/lenet_digit from LeNet; capture_en, core_go, lenet_go,
//   digit/digit_valid, busy, timeout_err, frame_cnt (all registered).
module inference_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 2400000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
  parameter int unsigned FRAME_CNT_W    = 8
) (
  input  logic                   clk24,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   pause,
  input  logic                   capture_end,
  input  logic                   core_end,
  input  logic                   lenet_ready,
  input  logic [3:0]             lenet_digit,
  output logic                   capture_en,
  output logic                   core_go,
  output logic                   lenet_go,
  output logic [3:0]             digit,
  output logic                   digit_valid,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_PROCESS,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] WD_LIMIT =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]       wd_q, wd_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic [3:0]             digit_q, digit_d;
  logic                   cap_en_q, cap_en_d;
  logic                   core_go_q, core_go_d;
  logic                   lenet_go_q, lenet_go_d;
  logic                   dv_q, dv_d;
  logic                   busy_q, busy_d;
  logic                   to_q, to_d;
  logic                   wd_run;
  logic                   expired;

  assign expired = (wd_q == WD_LIMIT);

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    digit_d    = digit_q;
    to_d       = to_q;
    core_go_d  = 1'b0;
    lenet_go_d = 1'b0;
    dv_d       = 1'b0;
    wd_run     = 1'b0;

    // Each waiting state checks its exit event before the watchdog,
    // so an event landing on the last allowed cycle still wins.
    unique case (state_q)
      S_IDLE: begin
        if (!enable) begin
          to_d = 1'b0;
        end else if (!pause && lenet_ready) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        wd_run = 1'b1;
        if (capture_end) begin
          state_d   = S_PROCESS;
          core_go_d = 1'b1;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (expired) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      S_PROCESS: begin
        wd_run = 1'b1;
        if (core_end) begin
          state_d    = S_LAUNCH;
          lenet_go_d = 1'b1;
        end else if (expired) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        wd_run = 1'b1;
        if (!lenet_ready) begin
          state_d = S_WAIT_DONE;
        end else if (expired) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        wd_run = 1'b1;
        if (lenet_ready) begin
          state_d = S_DONE;
          digit_d = lenet_digit;
          dv_d    = 1'b1;
        end else if (expired) begin
          state_d = S_IDLE;
          to_d    = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        frame_d = frame_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Counter restarts on every state change.
    if (!wd_run || (state_d != state_q)) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    cap_en_d = (state_d == S_CAPTURE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wd_q       <= '0;
      frame_q    <= '0;
      digit_q    <= '0;
      cap_en_q   <= 1'b0;
      core_go_q  <= 1'b0;
      lenet_go_q <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      frame_q    <= frame_d;
      digit_q    <= digit_d;
      cap_en_q   <= cap_en_d;
      core_go_q  <= core_go_d;
      lenet_go_q <= lenet_go_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      to_q       <= to_d;
    end
  end

  assign capture_en  = cap_en_q;
  assign core_go     = core_go_q;
  assign lenet_go    = lenet_go_q;
  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign busy        = busy_q;
  assign timeout_err = to_q;
  assign frame_cnt   = frame_q;

endmodule
